// File: rtl/master_in_port_pkg.sv
// Shared definitions for the slave-to-master read-data link: frame width and
// receive FSM state encoding.
package master_in_port_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Bit-counter width for a frame of w bits; at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/master_in_port_sipo_shift_reg.sv
// Serial-in/parallel-out register: writes din into bit idx when load_en is set,
// clear takes priority and zeroes the whole word.
module sipo_shift_reg
    import master_in_port_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned IDX_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load_en,
    input  logic [IDX_W-1:0] idx,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (clr) begin
            shift_d = '0;
        end else if (load_en) begin
            shift_d[idx] = din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/master_in_port.sv
// Receive end of the slave-to-master read-data link: handshake, LSB-first
// deserialisation and word hand-off. Optional MASTER_IN_DONE_CHECK_EN adds a frame-end check.
module master_in_port
    import master_in_port_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_en,
    input  logic                  slave_valid,
    input  logic                  rx_data,
    input  logic                  slave_tx_done,
    output logic                  master_ready,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  data_valid,
    output logic                  rx_busy,
    output logic                  rx_error
);

    localparam int unsigned     CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   dataout_q, dataout_d;
    logic                    data_valid_q, data_valid_d;
    logic                    rx_error_q, rx_error_d;
    logic                    rx_busy_q, rx_busy_d;
    logic                    master_ready_q, master_ready_d;

    logic                    handshake_c;
    logic                    shift_clr_c;
    logic                    shift_ld_c;
    logic [DATA_WIDTH-1:0]   shift_c;
    logic [DATA_WIDTH-1:0]   word_c;

    assign handshake_c = slave_valid & master_ready_q & rx_en;

    sipo_shift_reg #(
        .WIDTH (DATA_WIDTH),
        .IDX_W (CNT_W)
    ) u_sipo (
        .clk     (clk),
        .reset   (reset),
        .clr     (shift_clr_c),
        .load_en (shift_ld_c),
        .idx     (bit_cnt_q),
        .din     (rx_data),
        .q       (shift_c)
    );

    // Shift register is cleared at handshake, so the MSB slot is still zero here.
    assign word_c = shift_c | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 1));

`ifndef MASTER_IN_DONE_CHECK_EN
    logic unused_slave_tx_done_c;
    assign unused_slave_tx_done_c = slave_tx_done;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        dataout_d    = dataout_q;
        data_valid_d = 1'b0;
        rx_error_d   = 1'b0;
        shift_clr_c  = 1'b0;
        shift_ld_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (handshake_c) begin
                    state_d     = GAP;
                    shift_clr_c = 1'b1;
                end
            end
            GAP: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                shift_ld_c = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
`ifdef MASTER_IN_DONE_CHECK_EN
                    if (slave_tx_done) begin
                        dataout_d    = word_c;
                        data_valid_d = 1'b1;
                    end else begin
                        rx_error_d   = 1'b1;
                    end
`else
                    dataout_d    = word_c;
                    data_valid_d = 1'b1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Ready follows the state being entered so it is never high outside IDLE.
        master_ready_d = (state_d == IDLE) && rx_en;
        rx_busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            dataout_q      <= '0;
            data_valid_q   <= 1'b0;
            rx_error_q     <= 1'b0;
            rx_busy_q      <= 1'b0;
            master_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            dataout_q      <= dataout_d;
            data_valid_q   <= data_valid_d;
            rx_error_q     <= rx_error_d;
            rx_busy_q      <= rx_busy_d;
            master_ready_q <= master_ready_d;
        end
    end

    assign master_ready = master_ready_q;
    assign dataout      = dataout_q;
    assign data_valid   = data_valid_q;
    assign rx_busy      = rx_busy_q;
    assign rx_error     = rx_error_q;

endmodule

// File: tb/tb_master_in_port.sv
// Self-checking bench for master_in_port: directed frames plus randomized traffic
// against a frame-level reference model (tracks MASTER_IN_DONE_CHECK_EN).
module tb_master_in_port;

`ifdef MASTER_IN_DONE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_en;
    logic       slave_valid;
    logic       rx_data;
    logic       slave_tx_done;
    logic       master_ready;
    logic [7:0] dataout;
    logic       data_valid;
    logic       rx_busy;
    logic       rx_error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_dout = 8'h00;

    master_in_port dut (
        .clk           (clk),
        .reset         (reset),
        .rx_en         (rx_en),
        .slave_valid   (slave_valid),
        .rx_data       (rx_data),
        .slave_tx_done (slave_tx_done),
        .master_ready  (master_ready),
        .dataout       (dataout),
        .data_valid    (data_valid),
        .rx_busy       (rx_busy),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One frame as the slave would send it; called at a negedge, returns at the
    // negedge after the last-bit edge. drop_at = bit index where rx_en falls (-1: never).
    task automatic send_frame(input logic [7:0] w, input bit done, input int drop_at,
                              input bit wiggle, output int wait_cyc);
        bit exp_err;
        rx_en       = 1'b1;
        slave_valid = 1'b1;
        wait_cyc    = 0;
        while (!master_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_eq("handshake_ready", 32'(master_ready), 32'd1);
        if (!master_ready) return;
        @(negedge clk);
        check_eq("gap_busy", 32'(rx_busy), 32'd1);
        check_eq("gap_ready", 32'(master_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("mid_busy", 32'(rx_busy), 32'd1);
            check_eq("mid_valid", 32'(data_valid), 32'd0);
            rx_data       = w[i];
            slave_tx_done = (i == 7) ? done : 1'b0;
            if (i == drop_at) rx_en = 1'b0;
            if (wiggle) slave_valid = 1'($urandom);
        end
        @(negedge clk);
        slave_tx_done = 1'b0;
        exp_err = CHK_EN && !done;
        if (!exp_err) exp_dout = w;
        check_eq("end_valid", 32'(data_valid), 32'(!exp_err));
        check_eq("end_error", 32'(rx_error), 32'(exp_err));
        check_eq("end_dataout", 32'(dataout), 32'(exp_dout));
        check_eq("end_busy", 32'(rx_busy), 32'd0);
        check_eq("end_ready", 32'(master_ready), 32'(rx_en));
    endtask

    // Idle cycle after a frame: pulses must be gone and the word held.
    task automatic check_idle_after();
        slave_valid = 1'b0;
        @(negedge clk);
        check_eq("pulse_valid", 32'(data_valid), 32'd0);
        check_eq("pulse_error", 32'(rx_error), 32'd0);
        check_eq("hold_dataout", 32'(dataout), 32'(exp_dout));
    endtask

    initial begin
        int wc;
        reset         = 1'b1;
        rx_en         = 1'b0;
        slave_valid   = 1'b0;
        rx_data       = 1'b0;
        slave_tx_done = 1'b0;
        #1;
        check_eq("rst_ready", 32'(master_ready), 32'd0);
        check_eq("rst_dataout", 32'(dataout), 32'd0);
        check_eq("rst_valid", 32'(data_valid), 32'd0);
        check_eq("rst_busy", 32'(rx_busy), 32'd0);
        check_eq("rst_error", 32'(rx_error), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame
        send_frame(8'hA5, 1'b1, -1, 1'b0, wc);
        check_idle_after();

        // Back-to-back with slave_valid held
        send_frame(8'h3C, 1'b1, -1, 1'b0, wc);
        send_frame(8'hC3, 1'b1, -1, 1'b0, wc);
        check_eq("b2b_wait", 32'(wc), 32'd0);
        check_idle_after();

        // Reset after 4 bits of 0xFF
        rx_en       = 1'b1;
        slave_valid = 1'b1;
        wc = 0;
        while (!master_ready && wc < 50) begin @(negedge clk); wc++; end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data = 1'b1;
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_dout = 8'h00;
        check_eq("mrst_ready", 32'(master_ready), 32'd0);
        check_eq("mrst_busy", 32'(rx_busy), 32'd0);
        check_eq("mrst_dataout", 32'(dataout), 32'd0);
        check_eq("mrst_valid", 32'(data_valid), 32'd0);
        slave_valid = 1'b0;
        rx_data     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("mrst_no_valid", 32'(data_valid), 32'd0);
        end
        send_frame(8'h81, 1'b1, -1, 1'b0, wc);
        check_idle_after();

        // slave_valid without rx_en
        rx_en       = 1'b0;
        slave_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("noen_ready", 32'(master_ready), 32'd0);
            check_eq("noen_busy", 32'(rx_busy), 32'd0);
            check_eq("noen_dataout", 32'(dataout), 32'(exp_dout));
        end
        slave_valid = 1'b0;
        @(negedge clk);

        // rx_en dropped at bit 3
        send_frame(8'h5A, 1'b1, 3, 1'b0, wc);
        check_idle_after();
        check_eq("drop_ready", 32'(master_ready), 32'd0);

        // Missing done flag on last bit
        send_frame(8'h77, 1'b0, -1, 1'b0, wc);
        check_idle_after();

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            logic [7:0] w;
            bit done, wig;
            int drop;
            w    = 8'($urandom);
            done = ($urandom_range(0, 3) != 0);
            wig  = 1'($urandom);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_frame(w, done, drop, wig, wc);
            if (wc > 1) check_eq("rand_wait", 32'(wc), 32'd1);
            if ($urandom_range(0, 2) != 0) begin
                check_idle_after();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
